// File: rtl/led_pkg.sv
// Shared LED-block definitions: fader state encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package led_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } led_state_e;

  // Defaults shared by every LED block that needs a brightness ramp.
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_RAMP_DIV = 4096;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: free-running counter, frame-aligned duty latch, registered LED compare.
// Latency: LEVEL takes effect at the next frame boundary; LED is a registered output.
// Backpressure: none, runs every clock.
// Ports: CLK/RST (sync, active-high); LEVEL in (brightness); LED out (PWM pin).
module pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PWM_BITS-1:0] LEVEL,
  output logic                LED
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    // Latch on the edge the counter wraps so a frame never sees two duties.
    duty_d = (cnt_q == MAX) ? LEVEL : duty_q;
    // Compare against next-cycle counter/duty so the registered LED lines up
    // with cnt_q: LED high iff cnt_q < duty_q, forced high for full scale.
    led_d  = (duty_d == MAX) || (cnt_d < duty_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// LED fader: turns an on/off request into a linearly ramped PWM brightness.
// Latency: request registered once; first ramp step RAMP_DIV clocks after RISE/FALL entry.
// Backpressure: none; LED_REQ may toggle at any rate and is tracked every clock.
// Ports: CLK/RST (sync, active-high); LED_REQ in; LED, LEVEL, BUSY out.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                LED_REQ,
  output logic                LED,
  output logic [PWM_BITS-1:0] LEVEL,
  output logic                BUSY
);

  localparam int                  PRESC_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_TC = PRESC_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;

  logic                req_q, req_d;
  led_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                step_tick;

  always_comb begin
    req_d     = LED_REQ;
    state_d   = state_q;
    level_d   = level_q;
    // Prescaler falls back to 0: held in OFF/ON, cleared on every ramp entry
    // and on the step tick (wrap).
    presc_d   = '0;
    step_tick = (presc_q == PRESC_TC);

    case (state_q)
      ST_OFF: begin
        if (req_q) state_d = ST_RISE;
      end
      ST_RISE: begin
        // A reversal takes priority over a coincident step; LEVEL is kept.
        if (!req_q) begin
          state_d = ST_FALL;
        end else if (step_tick) begin
          if (level_q != MAX) level_d = level_q + 1'b1;
          if (level_d == MAX) state_d = ST_ON;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_ON: begin
        if (!req_q) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (req_q) begin
          state_d = ST_RISE;
        end else if (step_tick) begin
          if (level_q != '0) level_d = level_q - 1'b1;
          if (level_d == '0) state_d = ST_OFF;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q   <= 1'b0;
      state_q <= ST_OFF;
      level_q <= '0;
      presc_q <= '0;
    end else begin
      req_q   <= req_d;
      state_q <= state_d;
      level_q <= level_d;
      presc_q <= presc_d;
    end
  end

  assign LEVEL = level_q;
  assign BUSY  = (state_q == ST_RISE) || (state_q == ST_FALL);

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .CLK  (CLK),
    .RST  (RST),
    .LEVEL(level_q),
    .LED  (LED)
  );

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4, RAMP_DIV=4 (MAX=15, 16-clock frames).
// Expected LEVEL/BUSY/LED come from closed-form ramp timing computed here.
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic       led_req;
  logic       led;
  logic [3:0] level;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int ones;
  int exp_duty [5] = '{0, 3, 7, 11, 16};

  always #5 clk = ~clk;

  led_pwm_fader #(
    .PWM_BITS(4),
    .RAMP_DIV(4)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .LED_REQ(led_req),
    .LED    (led),
    .LEVEL  (level),
    .BUSY   (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  // LEVEL t edges after a request rises from OFF/LEVEL=0: RISE entered at t=2,
  // one step every 4 clocks from t=6, saturating at 15.
  function automatic int rise_lvl(input int t);
    if (t < 6) return 0;
    if ((t - 2) / 4 > 15) return 15;
    return (t - 2) / 4;
  endfunction

  // LEVEL k edges after FALL entry starting from level s.
  function automatic int fall_lvl(input int s, input int k);
    if (s - k / 4 < 0) return 0;
    return s - k / 4;
  endfunction

  initial begin
    // 1. Reset held two clocks with the request already high.
    rst     = 1'b1;
    led_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_led", i, led, 0);
      chk("rst_level", i, level, 0);
      chk("rst_busy", i, busy, 0);
    end

    // 2/3. Fade in from reset release; t=0 is the last reset edge.
    rst  = 1'b0;
    ones = 0;
    for (int t = 0; t < 80; t++) begin
      if (t > 0) tick();
      chk("in_level", t, level, rise_lvl(t));
      chk("in_busy", t, busy, (t >= 2 && t < 62));
      ones += int'(led);
      if (t % 16 == 15) begin
        chk("in_duty", t / 16, ones, exp_duty[t / 16]);
        ones = 0;
      end
    end

    // 5. Fade out from ON.
    led_req = 1'b0;
    for (int u = 1; u <= 70; u++) begin
      tick();
      chk("out_level", u, level, (u < 2) ? 15 : fall_lvl(15, u - 2));
      chk("out_busy", u, busy, (u >= 2 && u < 62));
      if (u <= 16) chk("out_led_full", u, led, 1);
      if (u >= 65) chk("out_led_off", u, led, 0);
    end

    // 4. Rise to 7, then reverse; FALL entered at v=32.
    led_req = 1'b1;
    for (int v = 1; v <= 80; v++) begin
      tick();
      if (v == 30) chk("rev_at7", v, level, 7);
      if (v == 30) led_req = 1'b0;
      chk("rev_level", v, level, (v < 32) ? rise_lvl(v) : fall_lvl(7, v - 32));
      chk("rev_busy", v, busy, (v >= 2 && v < 60));
      if (v >= 77) chk("rev_led_off", v, led, 0);
    end

    // 6. Reset in the middle of a rise at LEVEL=9.
    led_req = 1'b1;
    for (int w = 1; w <= 38; w++) begin
      tick();
      chk("pre_rst_level", w, level, rise_lvl(w));
    end
    chk("pre_rst_busy", 38, busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_level", 0, level, 0);
    chk("mid_rst_led", 0, led, 0);
    chk("mid_rst_busy", 0, busy, 0);
    rst = 1'b0;
    for (int x = 1; x <= 10; x++) begin
      tick();
      chk("restart_level", x, level, rise_lvl(x));
      chk("restart_busy", x, busy, (x >= 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
